// File: rtl/exe_stage_mc.sv
`default_nettype none
// ============================================================================
//  Module   : exe_stage_mc
//  Purpose  : Execute stage between the ID/EX register and the memory stage.
//             Forwards operands, builds operand 2 (shifted register, rotated
//             immediate or memory offset), runs the ALU, computes the branch
//             target and registers everything into the EX/MEM register.
//             Holds the output under downstream stall and back-pressures
//             decode while a multiply is in flight.
//  Build    : define EXE_MUL_EN to build the iterative multiplier
//             (EX_command 1010, MUL/DONE states, busy). Without it, 1010 is
//             an unused code and busy is tied low.
//  Ports    : clk, rst (async, active low)
//             in_valid/in_ready      - decode handshake
//             pc_in, signed_immediate, EX_command, SR_in, shifter_operand,
//             dst_in, mem_read_in, mem_write_in, imm, WB_en_in, B_in,
//             val_Rn_in, val_Rm_in   - decoded instruction
//             sel_src1/2, MEM_stage_val, WB_stage_val - forwarding
//             stall_in               - memory stage back-pressure
//             out_valid, dst_out, SR_out, ALU_res, val_Rm_out,
//             branch_address, mem_read_out, mem_write_out, WB_en_out,
//             B_out                  - EX/MEM register
//             busy                   - multiplier active
//  Revision : 1.0  initial release
// ============================================================================
module exe_stage_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic [23:0]           signed_immediate,
  input  logic [3:0]            EX_command,
  input  logic [3:0]            SR_in,
  input  logic [11:0]           shifter_operand,
  input  logic [3:0]            dst_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  imm,
  input  logic                  WB_en_in,
  input  logic                  B_in,
  input  logic [DATA_WIDTH-1:0] val_Rn_in,
  input  logic [DATA_WIDTH-1:0] val_Rm_in,
  input  logic [1:0]            sel_src1,
  input  logic [1:0]            sel_src2,
  input  logic [DATA_WIDTH-1:0] MEM_stage_val,
  input  logic [DATA_WIDTH-1:0] WB_stage_val,
  input  logic                  stall_in,
  output logic                  out_valid,
  output logic [3:0]            dst_out,
  output logic [3:0]            SR_out,
  output logic [DATA_WIDTH-1:0] ALU_res,
  output logic [DATA_WIDTH-1:0] val_Rm_out,
  output logic [DATA_WIDTH-1:0] branch_address,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  WB_en_out,
  output logic                  B_out,
  output logic                  busy
);

  localparam int M = DATA_WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

  state_t                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] w_src1, w_src2, w_shift, w_val2, w_imm_ext, w_branch;
  logic [DATA_WIDTH-1:0] w_add_b, w_alu_res;
  logic [DATA_WIDTH:0]   w_sum;
  logic                  w_add_cin, w_add_v, w_arith, w_known_op;
  logic [3:0]            w_alu_sr;
  logic                  w_is_mul, w_accept, w_load_alu;

  // Rotate right by 0..31; each stage rotates by a power of two reduced
  // modulo the datapath width so narrow datapaths wrap correctly.
  function automatic logic [DATA_WIDTH-1:0] ror_fn(input logic [DATA_WIDTH-1:0] v,
                                                   input logic [4:0] amt);
    logic [DATA_WIDTH-1:0] r;
    int s;
    r = v;
    for (int k = 0; k < 5; k++) begin
      s = (1 << k) % DATA_WIDTH;
      if (amt[k] && (s != 0)) r = (r >> s) | (r << (DATA_WIDTH - s));
    end
    return r;
  endfunction

  // Operand forwarding; 00 and 11 both select the register file.
  always_comb begin
    case (sel_src1)
      2'b01:   w_src1 = MEM_stage_val;
      2'b10:   w_src1 = WB_stage_val;
      default: w_src1 = val_Rn_in;
    endcase
    case (sel_src2)
      2'b01:   w_src2 = MEM_stage_val;
      2'b10:   w_src2 = WB_stage_val;
      default: w_src2 = val_Rm_in;
    endcase
  end

  // Operand 2 generation.
  always_comb begin
    case (shifter_operand[6:5])
      2'b00:   w_shift = w_src2 << shifter_operand[11:7];
      2'b01:   w_shift = w_src2 >> shifter_operand[11:7];
      2'b10:   w_shift = $unsigned($signed(w_src2) >>> shifter_operand[11:7]);
      default: w_shift = ror_fn(w_src2, shifter_operand[11:7]);
    endcase
    if (mem_read_in || mem_write_in)
      w_val2 = {{(DATA_WIDTH-12){1'b0}}, shifter_operand};
    else if (imm)
      w_val2 = ror_fn({{(DATA_WIDTH-8){1'b0}}, shifter_operand[7:0]},
                      {shifter_operand[11:8], 1'b0});
    else
      w_val2 = w_shift;
  end

  // Shared adder: subtraction is a + ~b + 1 (SBC uses C as carry-in), so the
  // carry out is directly the "no borrow" flag.
  always_comb begin
    w_add_b   = w_val2;
    w_add_cin = 1'b0;
    case (EX_command)
      4'b0011: w_add_cin = SR_in[1];
      4'b0100: begin w_add_b = ~w_val2; w_add_cin = 1'b1;     end
      4'b0101: begin w_add_b = ~w_val2; w_add_cin = SR_in[1]; end
      default: ;
    endcase
    w_sum   = {1'b0, w_src1} + {1'b0, w_add_b} + {{DATA_WIDTH{1'b0}}, w_add_cin};
    w_add_v = (w_src1[M] == w_add_b[M]) && (w_sum[M] != w_src1[M]);
  end

  always_comb begin
    w_alu_res  = '0;
    w_alu_sr   = SR_in;
    w_arith    = 1'b0;
    w_known_op = 1'b1;
    case (EX_command)
      4'b0001: w_alu_res = w_val2;
      4'b1001: w_alu_res = ~w_val2;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
        w_alu_res = w_sum[M:0];
        w_arith   = 1'b1;
      end
      4'b0110: w_alu_res = w_src1 & w_val2;
      4'b0111: w_alu_res = w_src1 | w_val2;
      4'b1000: w_alu_res = w_src1 ^ w_val2;
      default: w_known_op = 1'b0;
    endcase
    if (w_known_op)
      w_alu_sr = {w_alu_res[M], (w_alu_res == '0),
                  w_arith ? w_sum[DATA_WIDTH] : SR_in[1],
                  w_arith ? w_add_v           : SR_in[0]};
  end

  // Branch offset sign extension for any datapath width.
  if (DATA_WIDTH > 24) begin : g_imm_sext
    assign w_imm_ext = {{(DATA_WIDTH-24){signed_immediate[23]}}, signed_immediate};
  end else if (DATA_WIDTH == 24) begin : g_imm_same
    assign w_imm_ext = signed_immediate;
  end else begin : g_imm_trunc
    assign w_imm_ext = signed_immediate[DATA_WIDTH-1:0];
  end

  assign w_branch = pc_in + {{(DATA_WIDTH-1){1'b0}}, 1'b1} + w_imm_ext;

  // Handshake: ready only in IDLE, out of reset and without downstream stall.
  assign in_ready   = rst && (r_state == S_IDLE) && !stall_in;
  assign w_accept   = in_valid && in_ready;
  assign w_load_alu = w_accept && !w_is_mul;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

`ifdef EXE_MUL_EN
  localparam int MUL_STEPS = DATA_WIDTH / MUL_BITS;
  localparam int CNT_W     = $clog2(MUL_STEPS + 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_mcand, r_mplier, r_acc, w_pp;
  logic [DATA_WIDTH-1:0] r_mul_rm, r_mul_br;
  logic [3:0]            r_mul_dst, r_mul_ctl;
  logic [1:0]            r_mul_cv;
  logic                  w_mul_last, w_load_mul;

  assign w_is_mul   = (EX_command == 4'b1010);
  assign w_pp       = r_mcand * {{(DATA_WIDTH-MUL_BITS){1'b0}}, r_mplier[MUL_BITS-1:0]};
  assign w_mul_last = (r_cnt == CNT_W'(MUL_STEPS - 1));
  assign w_load_mul = (r_state == S_DONE) && !stall_in;
  assign busy       = (r_state == S_MUL);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_next = S_MUL;
      S_MUL:   if (w_mul_last)           w_state_next = S_DONE;
      S_DONE:  if (!stall_in)            w_state_next = S_IDLE;
      default:                           w_state_next = S_IDLE;
    endcase
  end

  // Shift-add multiplier: MUL_BITS of the multiplier retired per cycle; the
  // counter keeps running under stall, only the DONE hand-off waits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_mul_rm  <= '0;
      r_mul_br  <= '0;
      r_mul_dst <= '0;
      r_mul_ctl <= '0;
      r_mul_cv  <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt     <= '0;
      r_mcand   <= w_src1;
      r_mplier  <= w_src2;
      r_acc     <= '0;
      r_mul_rm  <= w_src2;
      r_mul_br  <= w_branch;
      r_mul_dst <= dst_in;
      r_mul_ctl <= {mem_read_in, mem_write_in, WB_en_in, B_in};
      r_mul_cv  <= SR_in[1:0];
    end else if (r_state == S_MUL) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_acc    <= r_acc + w_pp;
      r_mcand  <= r_mcand << MUL_BITS;
      r_mplier <= r_mplier >> MUL_BITS;
    end
  end
`else
  assign w_is_mul     = 1'b0;
  assign w_state_next = S_IDLE;
  assign busy         = 1'b0;
`endif

  // EX/MEM output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid      <= 1'b0;
      dst_out        <= '0;
      SR_out         <= '0;
      ALU_res        <= '0;
      val_Rm_out     <= '0;
      branch_address <= '0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      WB_en_out      <= 1'b0;
      B_out          <= 1'b0;
    end else if (w_load_alu) begin
      out_valid      <= 1'b1;
      dst_out        <= dst_in;
      SR_out         <= w_alu_sr;
      ALU_res        <= w_alu_res;
      val_Rm_out     <= w_src2;
      branch_address <= w_branch;
      mem_read_out   <= mem_read_in;
      mem_write_out  <= mem_write_in;
      WB_en_out      <= WB_en_in;
      B_out          <= B_in;
    end
`ifdef EXE_MUL_EN
    else if (w_load_mul) begin
      out_valid      <= 1'b1;
      dst_out        <= r_mul_dst;
      SR_out         <= {r_acc[M], (r_acc == '0), r_mul_cv};
      ALU_res        <= r_acc;
      val_Rm_out     <= r_mul_rm;
      branch_address <= r_mul_br;
      {mem_read_out, mem_write_out, WB_en_out, B_out} <= r_mul_ctl;
    end
`endif
    else if (!stall_in) begin
      // Previous result consumed and nothing new to present.
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exe_stage_mc
//  Purpose  : Directed self-checking bench for exe_stage_mc (default widths).
//             Multiplier scenarios are selected with EXE_MUL_EN; without it
//             the 1010 code is checked as an unused operation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exe_stage_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] pc_in;
  logic [23:0] signed_immediate;
  logic [3:0]  EX_command, SR_in, dst_in;
  logic [11:0] shifter_operand;
  logic        mem_read_in, mem_write_in, imm, WB_en_in, B_in;
  logic [31:0] val_Rn_in, val_Rm_in, MEM_stage_val, WB_stage_val;
  logic [1:0]  sel_src1, sel_src2;
  logic        stall_in, out_valid;
  logic [3:0]  dst_out, SR_out;
  logic [31:0] ALU_res, val_Rm_out, branch_address;
  logic        mem_read_out, mem_write_out, WB_en_out, B_out, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exe_stage_mc #(.DATA_WIDTH(32), .MUL_BITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .signed_immediate(signed_immediate), .EX_command(EX_command),
    .SR_in(SR_in), .shifter_operand(shifter_operand), .dst_in(dst_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .imm(imm),
    .WB_en_in(WB_en_in), .B_in(B_in), .val_Rn_in(val_Rn_in), .val_Rm_in(val_Rm_in),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .MEM_stage_val(MEM_stage_val),
    .WB_stage_val(WB_stage_val), .stall_in(stall_in), .out_valid(out_valid),
    .dst_out(dst_out), .SR_out(SR_out), .ALU_res(ALU_res), .val_Rm_out(val_Rm_out),
    .branch_address(branch_address), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .WB_en_out(WB_en_out), .B_out(B_out), .busy(busy)
  );

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] rn, rm;
    logic        im;
    logic [11:0] so;
    logic [3:0]  sr, exp_sr;
    logic [31:0] exp_res;
  } vec_t;

  task automatic idle_inputs();
    in_valid = 0; pc_in = 0; signed_immediate = 0; EX_command = 0; SR_in = 0;
    shifter_operand = 0; dst_in = 0; mem_read_in = 0; mem_write_in = 0; imm = 0;
    WB_en_in = 0; B_in = 0; val_Rn_in = 0; val_Rm_in = 0; sel_src1 = 0; sel_src2 = 0;
    MEM_stage_val = 0; WB_stage_val = 0; stall_in = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (ALU_res !== 32'h0)  begin n_fail++; $display("FAIL reset_alu_res: got %h want 0", ALU_res); end
    n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({SR_out, WB_en_out, B_out} !== 6'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 0", {SR_out, WB_en_out, B_out}); end
    @(negedge clk) rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_fwd();
    @(negedge clk); idle_inputs();
    in_valid = 1; EX_command = 4'b0010; sel_src1 = 2'b01; MEM_stage_val = 32'h7FFFFFFF;
    val_Rn_in = 32'h0BAD0BAD; imm = 1; shifter_operand = 12'h001;
    @(posedge clk); #1; in_valid = 0;
    n_cmp++; if (ALU_res !== 32'h80000000) begin n_fail++; $display("FAIL add_fwd_res: got %h want 80000000", ALU_res); end
    n_cmp++; if (SR_out !== 4'b1001)       begin n_fail++; $display("FAIL add_fwd_sr: got %b want 1001", SR_out); end
    n_cmp++; if (out_valid !== 1'b1)       begin n_fail++; $display("FAIL add_fwd_valid: got %b want 1", out_valid); end
  endtask

  task automatic test_sub_rot();
    @(negedge clk); idle_inputs();
    in_valid = 1; EX_command = 4'b0100; val_Rn_in = 32'd5; imm = 1; shifter_operand = 12'h105;
    WB_en_in = 1; dst_in = 4'd3;
    @(posedge clk); #1; in_valid = 0;
    n_cmp++; if (ALU_res !== 32'hC0000004) begin n_fail++; $display("FAIL sub_rot_res: got %h want C0000004", ALU_res); end
    n_cmp++; if (SR_out !== 4'b1000)       begin n_fail++; $display("FAIL sub_rot_sr: got %b want 1000", SR_out); end
    n_cmp++; if ({dst_out, WB_en_out} !== {4'd3, 1'b1}) begin n_fail++; $display("FAIL sub_rot_ctl: got %h/%b want 3/1", dst_out, WB_en_out); end
  endtask

  task automatic test_mem_offset();
    @(negedge clk); idle_inputs();
    in_valid = 1; EX_command = 4'b0010; mem_write_in = 1; val_Rn_in = 32'h100;
    shifter_operand = 12'hFFC; sel_src2 = 2'b10; WB_stage_val = 32'hDEADBEEF; val_Rm_in = 32'h1;
    @(posedge clk); #1; in_valid = 0;
    n_cmp++; if (ALU_res !== 32'h10FC)        begin n_fail++; $display("FAIL mem_res: got %h want 000010FC", ALU_res); end
    n_cmp++; if (val_Rm_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mem_rm_fwd: got %h want DEADBEEF", val_Rm_out); end
    n_cmp++; if ({mem_read_out, mem_write_out} !== 2'b01) begin n_fail++; $display("FAIL mem_ctl: got %b want 01", {mem_read_out, mem_write_out}); end
  endtask

  task automatic test_branch();
    @(negedge clk); idle_inputs();
    in_valid = 1; pc_in = 32'h10; signed_immediate = 24'hFFFFFE; B_in = 1; SR_in = 4'b0110;
    @(posedge clk); #1; in_valid = 0;
    n_cmp++; if (branch_address !== 32'h0F) begin n_fail++; $display("FAIL branch_addr: got %h want 0000000F", branch_address); end
    n_cmp++; if (B_out !== 1'b1)            begin n_fail++; $display("FAIL branch_b: got %b want 1", B_out); end
    n_cmp++; if ({ALU_res, SR_out} !== {32'h0, 4'b0110}) begin n_fail++; $display("FAIL branch_nop: got %h/%b want 0/0110", ALU_res, SR_out); end
  endtask

  task automatic test_alu_table();
    vec_t v[12];
    v[0]  = '{4'b0001, 32'h0,        32'h80000010, 1'b0, 12'h240, 4'b0011, 4'b1011, 32'hF8000001}; // MOV ASR#4
    v[1]  = '{4'b1001, 32'h0,        32'h80000010, 1'b0, 12'h460, 4'b0000, 4'b1000, 32'hEF7FFFFF}; // MVN ROR#8
    v[2]  = '{4'b0010, 32'hFFFFFFFF, 32'h80000010, 1'b0, 12'hFA0, 4'b0000, 4'b0110, 32'h0};        // ADD LSR#31
    v[3]  = '{4'b0011, 32'h1,        32'h0,        1'b1, 12'h0FF, 4'b0010, 4'b0000, 32'h101};      // ADC C=1
    v[4]  = '{4'b0101, 32'h5,        32'h0,        1'b1, 12'h003, 4'b0000, 4'b0010, 32'h1};        // SBC C=0
    v[5]  = '{4'b0100, 32'h7,        32'h0,        1'b1, 12'h007, 4'b0000, 4'b0110, 32'h0};        // SUB equal
    v[6]  = '{4'b0110, 32'hF0F0F0F0, 32'h0,        1'b1, 12'h0FF, 4'b0011, 4'b0011, 32'hF0};       // AND
    v[7]  = '{4'b1000, 32'hF0F0F0F0, 32'h0,        1'b1, 12'h4FF, 4'b0000, 4'b0000, 32'h0FF0F0F0}; // EOR ror imm
    v[8]  = '{4'b0111, 32'h0,        32'h0,        1'b1, 12'h000, 4'b0000, 4'b0100, 32'h0};        // ORR zero
    v[9]  = '{4'b0100, 32'h80000000, 32'h0,        1'b1, 12'h001, 4'b0000, 4'b0011, 32'h7FFFFFFF}; // SUB overflow
    v[10] = '{4'b0001, 32'h0,        32'h1,        1'b0, 12'h200, 4'b0000, 4'b0000, 32'h10};       // MOV LSL#4
    v[11] = '{4'b0010, 32'hFFFFFFFF, 32'h0,        1'b1, 12'h002, 4'b0000, 4'b0010, 32'h1};        // ADD carry
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); idle_inputs();
      in_valid = 1; EX_command = v[i].cmd; val_Rn_in = v[i].rn; val_Rm_in = v[i].rm;
      imm = v[i].im; shifter_operand = v[i].so; SR_in = v[i].sr;
      @(posedge clk); #1; in_valid = 0;
      n_cmp++; if (ALU_res !== v[i].exp_res) begin n_fail++; $display("FAIL alu_vec%0d_res: got %h want %h", i, ALU_res, v[i].exp_res); end
      n_cmp++; if (SR_out !== v[i].exp_sr)   begin n_fail++; $display("FAIL alu_vec%0d_sr: got %b want %b", i, SR_out, v[i].exp_sr); end
      n_cmp++; if (out_valid !== 1'b1)       begin n_fail++; $display("FAIL alu_vec%0d_valid: got %b want 1", i, out_valid); end
    end
  endtask

  task automatic test_stall_hold();
    @(negedge clk); idle_inputs();
    in_valid = 1; EX_command = 4'b0010; val_Rn_in = 32'h100; imm = 1; shifter_operand = 12'h023;
    @(posedge clk); #1;
    n_cmp++; if (ALU_res !== 32'h123) begin n_fail++; $display("FAIL stall_first: got %h want 00000123", ALU_res); end
    stall_in = 1; EX_command = 4'b0111; val_Rn_in = 32'hF;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b want 0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({out_valid, ALU_res} !== {1'b1, 32'h123}) begin n_fail++; $display("FAIL stall_hold: got %b/%h want 1/00000123", out_valid, ALU_res); end
    stall_in = 0; in_valid = 0;
    @(posedge clk); #1;
    n_cmp++; if ({out_valid, ALU_res} !== {1'b0, 32'h123}) begin n_fail++; $display("FAIL idle_clear: got %b/%h want 0/00000123", out_valid, ALU_res); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); idle_inputs();
    in_valid = 1; EX_command = 4'b0010; val_Rn_in = 32'd1; imm = 1; shifter_operand = 12'h002;
    @(posedge clk); #1;
    n_cmp++; if (ALU_res !== 32'd3) begin n_fail++; $display("FAIL b2b_first: got %h want 00000003", ALU_res); end
    val_Rn_in = 32'd10; shifter_operand = 12'h014;
    @(posedge clk); #1; in_valid = 0;
    n_cmp++; if ({out_valid, ALU_res} !== {1'b1, 32'd30}) begin n_fail++; $display("FAIL b2b_second: got %b/%h want 1/0000001E", out_valid, ALU_res); end
  endtask

`ifdef EXE_MUL_EN
  task automatic test_mul();
    int lat, low;
    @(negedge clk); idle_inputs();
    in_valid = 1; EX_command = 4'b1010; val_Rn_in = 32'h1234; val_Rm_in = 32'h10;
    dst_in = 4'd5; WB_en_in = 1; SR_in = 4'b0011;
    @(posedge clk); #1; in_valid = 0;
    lat = 1; low = 0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy: got %b want 1", busy); end
    while (!out_valid && lat < 30) begin
      if (!in_ready) low++;
      @(posedge clk); #1; lat++;
    end
    n_cmp++; if (lat !== 10)            begin n_fail++; $display("FAIL mul_latency: got %0d want 10", lat); end
    n_cmp++; if (low !== 9)             begin n_fail++; $display("FAIL mul_ready_low: got %0d want 9", low); end
    n_cmp++; if (ALU_res !== 32'h12340) begin n_fail++; $display("FAIL mul_res: got %h want 00012340", ALU_res); end
    n_cmp++; if ({SR_out, dst_out, WB_en_out} !== {4'b0011, 4'd5, 1'b1}) begin n_fail++; $display("FAIL mul_ctl: got %b/%h/%b want 0011/5/1", SR_out, dst_out, WB_en_out); end
    n_cmp++; if ({busy, in_ready} !== 2'b01) begin n_fail++; $display("FAIL mul_after: got %b want 01", {busy, in_ready}); end
  endtask

  task automatic test_mul_stall();
    logic early;
    @(negedge clk); idle_inputs();
    in_valid = 1; EX_command = 4'b1010; val_Rn_in = 32'd7; val_Rm_in = 32'd3;
    @(posedge clk); #1;
    // A pending ADD stays presented; it must wait until the multiply retires.
    EX_command = 4'b0010; imm = 1; shifter_operand = 12'h001;
    early = 0;
    repeat (7) begin @(posedge clk); #1; if (out_valid || in_ready) early = 1; end
    stall_in = 1;
    repeat (3) begin @(posedge clk); #1; if (out_valid || in_ready) early = 1; end
    n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL mul_stall_early: got %b want 0", early); end
    stall_in = 0;
    @(posedge clk); #1;
    n_cmp++; if ({out_valid, ALU_res} !== {1'b1, 32'h15}) begin n_fail++; $display("FAIL mul_stall_res: got %b/%h want 1/00000015", out_valid, ALU_res); end
    @(posedge clk); #1; in_valid = 0;
    n_cmp++; if ({out_valid, ALU_res} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL mul_stall_next: got %b/%h want 1/00000008", out_valid, ALU_res); end
  endtask
`else
  task automatic test_unused_code();
    @(negedge clk); idle_inputs();
    in_valid = 1; EX_command = 4'b1010; val_Rn_in = 32'h1234; val_Rm_in = 32'h10; SR_in = 4'b0101;
    @(posedge clk); #1; in_valid = 0;
    n_cmp++; if ({out_valid, ALU_res} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL unused_res: got %b/%h want 1/0", out_valid, ALU_res); end
    n_cmp++; if ({SR_out, busy} !== {4'b0101, 1'b0}) begin n_fail++; $display("FAIL unused_sr: got %b/%b want 0101/0", SR_out, busy); end
  endtask
`endif

  task automatic test_reset_mid_mul();
    @(negedge clk); idle_inputs();
    in_valid = 1; EX_command = 4'b0010; val_Rn_in = 32'd2; imm = 1; shifter_operand = 12'h003;
    @(posedge clk); #1;
    n_cmp++; if ({out_valid, ALU_res} !== {1'b1, 32'd5}) begin n_fail++; $display("FAIL pre_reset_add: got %b/%h want 1/00000005", out_valid, ALU_res); end
    EX_command = 4'b1010; val_Rn_in = 32'h1234; val_Rm_in = 32'h10; imm = 0; shifter_operand = 0;
    @(posedge clk); #1; in_valid = 0;
    repeat (2) @(posedge clk);
`ifdef EXE_MUL_EN
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
`endif
    @(negedge clk) rst = 1'b0;
    #1;
    n_cmp++; if ({busy, out_valid, in_ready} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_flags: got %b want 000", {busy, out_valid, in_ready}); end
    n_cmp++; if (ALU_res !== 32'h0) begin n_fail++; $display("FAIL mid_reset_res: got %h want 0", ALU_res); end
    @(negedge clk) rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    in_valid = 1; EX_command = 4'b0010; val_Rn_in = 32'd10; imm = 1; shifter_operand = 12'h005;
    @(posedge clk); #1; in_valid = 0;
    n_cmp++; if ({out_valid, ALU_res} !== {1'b1, 32'd15}) begin n_fail++; $display("FAIL post_reset_add: got %b/%h want 1/0000000F", out_valid, ALU_res); end
  endtask

  initial begin
    test_reset();
    test_add_fwd();
    test_sub_rot();
    test_mem_offset();
    test_branch();
    test_alu_table();
    test_stall_hold();
    test_back_to_back();
`ifdef EXE_MUL_EN
    test_mul();
    test_mul_stall();
`else
    test_unused_code();
`endif
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
